// File: rtl/rv32i_pkg.sv
// Shared types for the rv32i memory subsystem: RAM operation codes,
// arbiter port identifiers and the RAM arbiter state encoding.
package rv32i;

    // Operation presented to the single-port word RAM.
    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_op_e;

    // Requester identity; also the bit index of that requester in req/gnt vectors.
    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_e;

    // Arbiter FSM encoding, kept as plain constants for legacy tools.
    typedef logic [1:0] arb_state_e;

    localparam arb_state_e IDLE  = 2'd0;
    localparam arb_state_e I_RSP = 2'd1;
    localparam arb_state_e D_RSP = 2'd2;
    localparam arb_state_e D_WR  = 2'd3;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. When both requesters are active the one
// that was not granted last wins; a lone requester is always granted.
module rr_arb2
    import rv32i::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    port_e last_q;

    // Pick the winner for this cycle from the request pattern and history.
    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (last_q == PORT_I) ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Remember which port won last; starts at I so D wins the first conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (!rst_n) begin
            last_q <= PORT_I;
        end else if (gnt[PORT_I]) begin
            last_q <= PORT_I;
        end else if (gnt[PORT_D]) begin
            last_q <= PORT_D;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one registered-address word RAM between instruction fetch (I) and
// load/store (D). Reads return one cycle after grant; stores take an address
// cycle followed by a write cycle, merging sub-word lanes with the old word.
// A new request may be granted in every state, so reads stream at 1 word/cycle.
module ram_arbiter
    import rv32i::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_wack,

    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output mem_op_e     ram_mem_op,
    input  logic [31:0] ram_rdata
);

    arb_state_e  state_q;
    arb_state_e  state_d;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [1:0]  gnt;
    logic [31:0] sel_addr;
    logic        unused_addr_bits;

    // Grants are masked while reset is asserted so every output reads 0 at once.
    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (rst_n),
        .req   ({d_req, i_req}),
        .gnt   (gnt)
    );

    assign i_gnt = gnt[PORT_I];
    assign d_gnt = gnt[PORT_D];

    // The granted address goes straight to the RAM, which latches it at the edge.
    assign sel_addr = d_gnt ? d_addr : (i_gnt ? i_addr : 32'd0);

    // Only the word index inside the decoded window reaches the RAM; upper bits alias.
    assign ram_addr = {{(32 - ADDR_W){1'b0}}, sel_addr[ADDR_W-1:2], 2'b00};

    assign unused_addr_bits = ^{sel_addr[31:ADDR_W], sel_addr[1:0]};

    // Next state follows whatever is granted this cycle, from any state.
    always_comb begin
        state_d = IDLE;
        if (d_gnt) begin
            state_d = d_we ? D_WR : D_RSP;
        end else if (i_gnt) begin
            state_d = I_RSP;
        end
    end

    // Response-phase outputs, including the byte-lane merge for stores.
    always_comb begin
        i_rvalid   = 1'b0;
        i_rdata    = 32'd0;
        d_rvalid   = 1'b0;
        d_rdata    = 32'd0;
        d_wack     = 1'b0;
        ram_wdata  = 32'd0;
        ram_mem_op = MEM_NONE;
        case (state_q)
            I_RSP: begin
                i_rvalid = 1'b1;
                i_rdata  = ram_rdata;
            end
            D_RSP: begin
                d_rvalid = 1'b1;
                d_rdata  = ram_rdata;
            end
            D_WR: begin
                // ram_rdata holds the old word at the store index, read in the address cycle.
                for (int b = 0; b < 4; b++) begin
                    ram_wdata[8*b +: 8] = wstrb_q[b] ? wdata_q[8*b +: 8] : ram_rdata[8*b +: 8];
                end
                // An all-zero strobe commits nothing but is still acknowledged.
                ram_mem_op = (wstrb_q != 4'b0000) ? MEM_STORE : MEM_NONE;
                d_wack     = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // FSM state and captured store fields; the requester may change them after grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wdata_q <= 32'd0;
            wstrb_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            if (d_gnt) begin
                wdata_q <= d_wdata;
                wstrb_q <= d_wstrb;
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural registered-address RAM
// and per-port response scoreboards.
module tb_ram_arbiter;
    import rv32i::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, i_gnt, i_rvalid;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid, d_wack;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_wstrb;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    mem_op_e     ram_mem_op;

    int checks = 0;
    int errors = 0;

    logic [31:0] i_exp_q[$];
    logic [31:0] d_exp_q[$];
    int          wack_exp = 0;

    // RAM model: address latched at the edge, registered read (read-before-write),
    // MEM_STORE writes to the index latched on the previous edge.
    logic [31:0] mem [0:1023];
    logic [9:0]  idx_q;
    logic [31:0] rdata_q;
    logic        pre_we = 1'b0;
    logic [9:0]  pre_idx = '0;
    logic [31:0] pre_data = '0;

    always @(posedge clk) begin
        rdata_q <= mem[ram_addr[11:2]];
        if (pre_we) mem[pre_idx] <= pre_data;
        else if (ram_mem_op == MEM_STORE) mem[idx_q] <= ram_wdata;
        idx_q <= ram_addr[11:2];
    end
    assign ram_rdata = rdata_q;

    ram_arbiter #(.ADDR_W(12)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_gnt      (i_gnt),
        .i_rvalid   (i_rvalid),
        .i_rdata    (i_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_wstrb    (d_wstrb),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .d_wack     (d_wack),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_mem_op (ram_mem_op),
        .ram_rdata  (ram_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every response or store ack must have been expected.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (i_rvalid) begin
                check("i_rsp_expected", 32'(i_exp_q.size() != 0), 32'd1);
                if (i_exp_q.size() != 0) check("i_rdata", i_rdata, i_exp_q.pop_front());
            end
            if (d_rvalid) begin
                check("d_rsp_expected", 32'(d_exp_q.size() != 0), 32'd1);
                if (d_exp_q.size() != 0) check("d_rdata", d_rdata, d_exp_q.pop_front());
            end
            if (d_wack) begin
                check("d_wack_expected", 32'(wack_exp > 0), 32'd1);
                if (wack_exp > 0) wack_exp--;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int idx, input logic [31:0] data);
        pre_we   = 1'b1;
        pre_idx  = 10'(idx);
        pre_data = data;
        step();
        pre_we = 1'b0;
    endtask

    // Waits (bounded) for the grant; returns at the negedge of the grant cycle.
    task automatic wait_grant(input logic is_d);
        logic g;
        g = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            g = is_d ? d_gnt : i_gnt;
            if (g === 1'b1) break;
            @(posedge clk);
            #1;
        end
        check(is_d ? "d_gnt" : "i_gnt", 32'(g), 32'd1);
    endtask

    task automatic do_fetch(input logic [31:0] a, input logic [31:0] exp);
        i_req = 1'b1;
        i_addr = a;
        i_exp_q.push_back(exp);
        wait_grant(1'b0);
        step();
        i_req = 1'b0;
        i_addr = '0;
    endtask

    task automatic d_load(input logic [31:0] a, input logic [31:0] exp);
        d_req = 1'b1;
        d_we = 1'b0;
        d_addr = a;
        d_exp_q.push_back(exp);
        wait_grant(1'b1);
        step();
        d_req = 1'b0;
    endtask

    task automatic check_quiet_outputs(input string tag);
        check({tag, "_ctl"}, 32'({i_gnt, d_gnt, i_rvalid, d_rvalid, d_wack}), 32'd0);
        check({tag, "_mem_op"}, 32'(ram_mem_op), 32'(MEM_NONE));
        check({tag, "_i_rdata"}, i_rdata, 32'd0);
        check({tag, "_d_rdata"}, d_rdata, 32'd0);
        check({tag, "_ram_addr"}, ram_addr, 32'd0);
        check({tag, "_ram_wdata"}, ram_wdata, 32'd0);
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_i_pending"}, 32'(i_exp_q.size()), 32'd0);
        check({tag, "_d_pending"}, 32'(d_exp_q.size()), 32'd0);
        check({tag, "_wack_pending"}, 32'(wack_exp), 32'd0);
    endtask

    task automatic apply_reset();
        i_req = 1'b0;
        d_req = 1'b0;
        rst_n = 1'b0;
        #1;
        check_quiet_outputs("rst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [31:0] t1_addr [2] = '{32'h0000_0010, 32'h0000_1010};

    initial begin
        rst_n = 1'b0;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        step();
        check_quiet_outputs("reset");
        preload(0,  32'h1000_0000);
        preload(1,  32'h1000_0004);
        preload(2,  32'h1000_0008);
        preload(4,  32'hDEAD_BEEF);
        preload(8,  32'h1122_3344);
        preload(12, 32'hC0DE_0030);
        preload(13, 32'hDA7A_0034);
        preload(16, 32'h0BAD_F00D);
        preload(24, 32'h600D_600D);
        rst_n = 1'b1;
        step();

        // 1: single fetch, plus the same word through an aliased upper address.
        for (int k = 0; k < 2; k++) begin
            i_req = 1'b1;
            i_addr = t1_addr[k];
            i_exp_q.push_back(32'hDEAD_BEEF);
            @(negedge clk);
            check("t1_i_gnt", 32'(i_gnt), 32'd1);
            check("t1_ram_addr", ram_addr, 32'h0000_0010);
            step();
            i_req = 1'b0;
            @(negedge clk);
            check("t1_i_rvalid", 32'(i_rvalid), 32'd1);
            step();
        end

        // 2: streaming fetch with i_req held.
        i_req = 1'b1;
        i_addr = 32'h0;
        i_exp_q.push_back(32'h1000_0000);
        i_exp_q.push_back(32'h1000_0004);
        i_exp_q.push_back(32'h1000_0008);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t2_i_gnt", 32'(i_gnt), 32'd1);
            if (k > 0) check("t2_i_rvalid", 32'(i_rvalid), 32'd1);
            step();
            i_addr = 32'(4 * (k + 1));
        end
        i_req = 1'b0;
        @(negedge clk);
        check("t2_last_rvalid", 32'(i_rvalid), 32'd1);
        step();

        // 3: byte store into lane 2, then load back the merged word.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h00AB_0000; d_wstrb = 4'b0100;
        wack_exp++;
        wait_grant(1'b1);
        step();
        d_req = 1'b0; d_wdata = 32'hFFFF_FFFF; d_wstrb = 4'b1111;
        check("t3_wack", 32'(d_wack), 32'd1);
        check("t3_mem_op", 32'(ram_mem_op), 32'(MEM_STORE));
        check("t3_ram_wdata", ram_wdata, 32'h11AB_3344);
        step();
        d_load(32'h20, 32'h11AB_3344);

        // 3b: store with no byte enables is acknowledged but writes nothing.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h1234_5678; d_wstrb = 4'b0000;
        wack_exp++;
        wait_grant(1'b1);
        step();
        d_req = 1'b0;
        check("t3b_wack", 32'(d_wack), 32'd1);
        check("t3b_mem_op", 32'(ram_mem_op), 32'(MEM_NONE));
        step();
        d_load(32'h20, 32'h11AB_3344);
        step();
        check_drained("t3");

        // 4: simultaneous requests from reset alternate D, I, D, I.
        apply_reset();
        i_req = 1'b1; i_addr = 32'h30;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h34;
        i_exp_q.push_back(32'hC0DE_0030);
        i_exp_q.push_back(32'hC0DE_0030);
        d_exp_q.push_back(32'hDA7A_0034);
        d_exp_q.push_back(32'hDA7A_0034);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t4_d_gnt", 32'(d_gnt), 32'(k % 2 == 0));
            check("t4_i_gnt", 32'(i_gnt), 32'(k % 2 == 1));
            step();
        end
        i_req = 1'b0;
        d_req = 1'b0;
        step();
        step();
        check_drained("t4");

        // 5: fetch granted during the store's write cycle sees the old word.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h5555_5555; d_wstrb = 4'b1111;
        wack_exp++;
        wait_grant(1'b1);
        step();
        d_req = 1'b0;
        i_req = 1'b1; i_addr = 32'h40;
        i_exp_q.push_back(32'h0BAD_F00D);
        @(negedge clk);
        check("t5_i_gnt_in_dwr", 32'(i_gnt), 32'd1);
        check("t5_mem_op", 32'(ram_mem_op), 32'(MEM_STORE));
        step();
        i_req = 1'b0;
        do_fetch(32'h40, 32'h5555_5555);
        step();
        check_drained("t5");

        // 6: reset asserted in the write cycle aborts the store.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h60; d_wdata = 32'hFFFF_FFFF; d_wstrb = 4'b1111;
        wait_grant(1'b1);
        step();
        d_req = 1'b0;
        check("t6_in_dwr", 32'(d_wack), 32'd1);
        #1;
        rst_n = 1'b0;
        i_req = 1'b1; i_addr = 32'h10;
        #1;
        check_quiet_outputs("t6_rst");
        step();
        i_req = 1'b0;
        step();
        rst_n = 1'b1;
        d_load(32'h60, 32'h600D_600D);
        step();
        step();
        check_drained("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
